// File: rtl/display_scanner_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
package display_scanner_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {a,b,c,d,e,f,g,dp} patterns for hex digits 0..F, dp off.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

endpackage

// File: rtl/display.sv
// Combinational hex-to-segment decoder, active-low, decimal point off.
module display
  import display_scanner_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg_c
);

  assign seg_c = SEG_TABLE[hex];

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with a double-buffered
// value, per-digit blanking gap, and registered pin outputs.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned SHOW_CYCLES  = 4096,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

  scan_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [DIG_W-1:0] digit, digit_next;

  logic [VAL_W-1:0]      act_value, act_value_next, pend_value, pend_value_next;
  logic [NUM_DIGITS-1:0] act_dp, act_dp_next, pend_dp, pend_dp_next;
  logic [NUM_DIGITS-1:0] act_blank, act_blank_next, pend_blank, pend_blank_next;
  logic                  pend_valid, pend_valid_next;

  logic [NUM_DIGITS-1:0] an_next;
  logic [7:0]            seg_next;
  logic                  frame_done_next;
  logic [3:0]            nibble_c;
  logic [7:0]            dec_c;

  // Scan sequencing and double-buffer update.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt + CNT_W'(1);
    digit_next      = digit;
    pend_value_next = load ? value      : pend_value;
    pend_dp_next    = load ? dp_mask    : pend_dp;
    pend_blank_next = load ? blank_mask : pend_blank;
    pend_valid_next = pend_valid | load;
    act_value_next  = act_value;
    act_dp_next     = act_dp;
    act_blank_next  = act_blank;

    if (!enable) begin
      state_next      = ST_OFF;
      cnt_next        = '0;
      digit_next      = '0;
      act_value_next  = pend_value_next;
      act_dp_next     = pend_dp_next;
      act_blank_next  = pend_blank_next;
      pend_valid_next = 1'b0;
    end else begin
      unique case (state)
        ST_OFF: begin
          state_next = ST_BLANK;
          cnt_next   = '0;
          digit_next = '0;
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_next = ST_SHOW;
            cnt_next   = '0;
          end
        end
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_next = ST_BLANK;
            cnt_next   = '0;
            digit_next = (digit == LAST_DIGIT) ? '0 : digit + DIG_W'(1);
            // Frame boundary: swap in the newest data, including a same-cycle load.
            if (digit == LAST_DIGIT) begin
              if (pend_valid_next) begin
                act_value_next = pend_value_next;
                act_dp_next    = pend_dp_next;
                act_blank_next = pend_blank_next;
              end
              pend_valid_next = 1'b0;
            end
          end
        end
        default: begin
          state_next = ST_OFF;
          cnt_next   = '0;
          digit_next = '0;
        end
      endcase
    end
  end

  assign nibble_c = 4'(act_value_next >> {digit_next, 2'b00});

  display u_display (
    .hex   (nibble_c),
    .seg_c (dec_c)
  );

  // Pin values for the upcoming cycle, so they line up with the state register.
  always_comb begin
    an_next         = '1;
    seg_next        = SEG_BLANK;
    frame_done_next = 1'b0;
    if (state_next == ST_SHOW) begin
      frame_done_next = (cnt_next == SHOW_LAST) && (digit_next == LAST_DIGIT);
      if (!act_blank_next[digit_next]) begin
        an_next[digit_next] = 1'b0;
        seg_next = {dec_c[7:1], dec_c[0] & ~act_dp_next[digit_next]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      digit      <= '0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
      an_n       <= '1;
      seg_n      <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      digit      <= digit_next;
      act_value  <= act_value_next;
      act_dp     <= act_dp_next;
      act_blank  <= act_blank_next;
      pend_value <= pend_value_next;
      pend_dp    <= pend_dp_next;
      pend_blank <= pend_blank_next;
      pend_valid <= pend_valid_next;
      an_n       <= an_next;
      seg_n      <= seg_next;
      frame_done <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner (N=4, BLANK=2, SHOW=4): stimulus queues
// expected per-cycle pin values, a negedge monitor pops and compares them.
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blank_mask = '0;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  display_scanner #(
    .NUM_DIGITS   (4),
    .BLANK_CYCLES (2),
    .SHOW_CYCLES  (4),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic [3:0] an;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each cycle, compare outputs against the expectation tagged with that cycle.
  always @(negedge clk) begin
    if (!done) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missed cyc=%0d: expectation never compared", q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (an_n !== e.an || seg_n !== e.seg || frame_done !== e.fd) begin
          miscompares++;
          $display("FAIL pins cyc=%0d: got an_n=%h seg_n=%h fd=%b, want an_n=%h seg_n=%h fd=%b",
                   cyc, an_n, seg_n, frame_done, e.an, e.seg, e.fd);
        end
      end
    end
  end

  // Frame-relative expectations; segs packs hand-decoded patterns {d3,d2,d1,d0}.
  task automatic push_frame(input int base, input logic [31:0] segs,
                            input logic [3:0] blank, input int k_lo, input int k_hi);
    for (int k = k_lo; k <= k_hi; k++) begin
      exp_t e;
      int d, ph;
      d = k / 6;
      ph = k % 6;
      e.cyc = base + k;
      e.an  = 4'hF;
      e.seg = 8'hFF;
      e.fd  = (k == 23);
      if (ph >= 2 && !blank[d]) begin
        e.an  = 4'(~(4'b0001 << d));
        e.seg = segs[d*8 +: 8];
      end
      q.push_back(e);
    end
  endtask

  task automatic push_off(input int c_lo, input int c_hi);
    for (int c = c_lo; c <= c_hi; c++) begin
      exp_t e;
      e.cyc = c;
      e.an  = 4'hF;
      e.seg = 8'hFF;
      e.fd  = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value = v;
    dp_mask = dp;
    blank_mask = bl;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Frame 0 (cycle 3 = reset edge): no load, all digits show 0.
    push_frame(3, 32'h03030303, 4'b0000, 0, 23);
    wait_cyc(3);
    rst = 1'b0;

    wait_cyc(7);
    do_load(16'h12AF, 4'b0100, 4'b0000);
    push_frame(27, 32'h9F241171, 4'b0000, 0, 23);

    // Mid-frame load during digit 1 of frame 1 waits for the boundary.
    wait_cyc(35);
    do_load(16'h8888, 4'b0000, 4'b0000);
    push_frame(51, 32'h01010101, 4'b0000, 0, 23);

    // Two loads in frame 2: the second wins.
    wait_cyc(54);
    do_load(16'h1111, 4'b0000, 4'b0000);
    wait_cyc(66);
    do_load(16'h2345, 4'b0000, 4'b0000);
    push_frame(75, 32'h250D9949, 4'b0000, 0, 23);

    // Load in the boundary cycle (frame 3 cycle 23) bypasses to active.
    wait_cyc(98);
    do_load(16'hC0DE, 4'b0001, 4'b0000);
    push_frame(99, 32'h63038560, 4'b0000, 0, 23);

    // Blank digits 1 and 3 from frame 5 on.
    wait_cyc(109);
    do_load(16'hC0DE, 4'b0001, 4'b1010);
    push_frame(123, 32'h63038560, 4'b1010, 0, 23);
    push_frame(147, 32'h63038560, 4'b1010, 0, 14);

    // Drop enable during SHOW of digit 2, load while dark, re-enable.
    wait_cyc(161);
    enable = 1'b0;
    push_off(162, 166);
    wait_cyc(163);
    do_load(16'h0007, 4'b0000, 4'b0000);
    wait_cyc(166);
    enable = 1'b1;
    push_frame(167, 32'h0303031F, 4'b0000, 0, 8);

    // Reset during SHOW of digit 1: buffers clear, scan restarts.
    wait_cyc(175);
    rst = 1'b1;
    push_frame(176, 32'h03030303, 4'b0000, 0, 23);
    wait_cyc(176);
    rst = 1'b0;

    wait_cyc(202);
    done = 1'b1;
    while (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover cyc=%0d: expectation never compared", q[0].cyc);
      void'(q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
